// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dpram round-robin arbiter.
// rr_pick works on a fixed 8-bit vector so any NREQ in 2..8 can use it.
package dpram_arb_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int MAX_REQ          = 8;
  localparam int DEF_ADDR_WIDTH   = 12;
  localparam int DEPTH            = 2**DEF_ADDR_WIDTH;

  // One-hot pick of the first set request after 'last', wrapping modulo nreq.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         last,
                                                 input int                 nreq);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int                 idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(last) + k) % nreq;
      if (k <= nreq && !found && req[3'(idx)]) begin
        gnt[3'(idx)] = 1'b1;
        found        = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/dpram_arbiter_rr_arbiter.sv
// NREQ-wide round-robin arbiter: combinational one-hot grant plus the
// last-granted pointer, which resets to NREQ-1 so requester 0 goes first.
module rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      last
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick;
  logic [2:0]         last_q;
  logic [2:0]         gnt_idx;

  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
  end

  assign pick = rr_pick(req_ext, last_q, NREQ);
  assign gnt  = en ? pick[NREQ-1:0] : '0;
  assign last = last_q;

  always_comb begin
    gnt_idx = last_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 3'(NREQ - 1);
    end else if (|gnt) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares one 1-cycle-latency dpram among NREQ requesters: zero-fill sweep
// after reset, then round-robin serialised commands with tagged read return.
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            req_gnt,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       init_done,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic [DATA_WIDTH/8-1:0]    mem_wmask,
  output logic [ADDR_WIDTH-1:0]      mem_waddr,
  output logic                       mem_wr_en,
  output logic [ADDR_WIDTH-1:0]      mem_raddr,
  output logic                       mem_rd_en,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  input  logic                       mem_rvalid,
  output state_t                     dbg_state
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  sweep_wr;
  logic [NREQ-1:0]       tag_q1, tag_q2;
  logic                  gnt_we;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic [2:0]            rr_last;

  assign dbg_state = state_q;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .en    (init_done),
    .req   (req),
    .gnt   (req_gnt),
    .last  (rr_last)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter wraps naturally on the terminal write, leaving it at 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_wr = 1'b0;
    case (state_q)
      S_INIT: begin
        if (!INIT_EN) begin
          state_d = S_RUN;
        end else begin
          sweep_wr = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (&cnt_q) state_d = S_RUN;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    gnt_we    = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_gnt[i]) begin
        gnt_we    = req_we[i];
        gnt_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Address/data hold when idle; only the enables pulse per command.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      init_done <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_waddr <= '0;
      mem_raddr <= '0;
      mem_wdata <= '0;
      tag_q1    <= '0;
      tag_q2    <= '0;
    end else begin
      init_done <= (state_q == S_RUN);
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      tag_q1    <= '0;
      tag_q2    <= tag_q1;
      if (sweep_wr) begin
        mem_wr_en <= 1'b1;
        mem_waddr <= cnt_q;
        mem_wdata <= '0;
      end else if (|req_gnt) begin
        if (gnt_we) begin
          mem_wr_en <= 1'b1;
          mem_waddr <= gnt_addr;
          mem_wdata <= gnt_wdata;
        end else begin
          mem_rd_en <= 1'b1;
          mem_raddr <= gnt_addr;
          tag_q1    <= req_gnt;
        end
      end
    end
  end

  // dpram ORs the mask into stored data, so it must stay clear.
  assign mem_wmask = '0;
  assign rsp_valid = tag_q2 & {NREQ{mem_rvalid}};
  assign rsp_data  = (|rsp_valid) ? mem_rdata : '0;

  logic unused_last;
  assign unused_last = ^rr_last;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Randomised scoreboard bench for dpram_arbiter with a behavioural dpram
// and a transaction-level reference model of arbitration and memory contents.
module tb_dpram_arbiter;
  import dpram_arb_pkg::*;

  localparam int NREQ  = 2;
  localparam int AW    = 4;
  localparam int DW    = 12;
  localparam int DEPTH = 16;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ-1:0]      req_we = '0;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*DW-1:0]   req_wdata = '0;
  logic [NREQ-1:0]      req_gnt;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 init_done;
  logic [DW-1:0]        mem_wdata;
  logic [DW/8-1:0]      mem_wmask;
  logic [AW-1:0]        mem_waddr;
  logic                 mem_wr_en;
  logic [AW-1:0]        mem_raddr;
  logic                 mem_rd_en;
  logic [DW-1:0]        mem_rdata = '0;
  logic                 mem_rvalid = 1'b0;
  state_t               dbg_state;

  dpram_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b1)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_gnt    (req_gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .init_done  (init_done),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_waddr  (mem_waddr),
    .mem_wr_en  (mem_wr_en),
    .mem_raddr  (mem_raddr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  int rel_cnt = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)          rel_cnt <= 0;
    else if (rel_cnt < 1000) rel_cnt <= rel_cnt + 1;
  end

  // ---------------- behavioural dpram (no reset, starts with junk) ----------------
  logic [DW-1:0] ram [DEPTH];
  bit            ram_loaded = 1'b0;
  always @(posedge sys_clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= DW'($urandom_range(1, 4095));
      ram_loaded <= 1'b1;
    end else if (mem_wr_en) begin
      ram[mem_waddr] <= mem_wdata | ((|mem_wmask) ? {DW{1'b1}} : {DW{1'b0}});
    end
    mem_rvalid <= mem_rd_en;
    if (mem_rd_en) mem_rdata <= ram[mem_raddr];
  end

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_pass = 0;
  bit wmask_bad = 1'b0;
  logic [DW-1:0]   exp_q[$];
  logic [NREQ-1:0] exp_vld_q[$];
  int              exp_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  int            last_m = NREQ - 1;
  logic [DW-1:0] ref_mem [DEPTH];

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Sweep writes appear on edges 1..DEPTH after release; grants from DEPTH+1.
  always @(negedge sys_clk) begin
    int              idx;
    logic [NREQ-1:0] exp_g;
    logic [AW-1:0]   a;
    if (!sys_rst_n) begin
      last_m = NREQ - 1;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      exp_q.delete();
      exp_vld_q.delete();
      exp_cyc_q.delete();
    end else begin
      if (rel_cnt <= DEPTH + 1) begin
        check("sweep_wr_en", 32'(mem_wr_en), 32'(rel_cnt >= 1 && rel_cnt <= DEPTH));
        check("init_done", 32'(init_done), 32'(rel_cnt >= DEPTH + 1));
        if (rel_cnt >= 1 && rel_cnt <= DEPTH) begin
          check("sweep_addr", 32'(mem_waddr), 32'(rel_cnt - 1));
          check("sweep_data", 32'(mem_wdata), 32'd0);
        end
      end
      exp_g = '0;
      idx   = (rel_cnt >= DEPTH + 1) ? pick(req, last_m) : -1;
      if (idx >= 0) exp_g[idx] = 1'b1;
      check("req_gnt", 32'(req_gnt), 32'(exp_g));
      if (idx >= 0) begin
        a = req_addr[idx*AW +: AW];
        if (req_we[idx]) begin
          ref_mem[a] = req_wdata[idx*DW +: DW];
        end else begin
          exp_q.push_back(ref_mem[a]);
          exp_vld_q.push_back(exp_g);
          exp_cyc_q.push_back(cyc + 2);
        end
        last_m = idx;
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge sys_clk) begin
    if (|mem_wmask) wmask_bad = 1'b1;
    if (sys_rst_n && mem_rvalid && rsp_valid == '0)
      check("stray_rvalid", 32'(rsp_valid), 32'(NREQ'(1)));
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        check("rsp_valid", 32'(rsp_valid), 32'(exp_vld_q.pop_front()));
        check("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
        check("rsp_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ-1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req       = r;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_INIT));
    sys_rst_n = 1'b1;
    // Both requesters pester through the sweep; no grant may appear.
    repeat (DEPTH + 2) drive(2'b11, 2'b00, 4'h3, 4'h4, '0, '0);

    drive(2'b01, 2'b01, 4'h5, 4'h0, 12'hABC, 12'h000);
    drive(2'b10, 2'b00, 4'h0, 4'h5, 12'h000, 12'h000);
    drive(2'b01, 2'b01, 4'h1, 4'h0, 12'h111, 12'h000);
    drive(2'b10, 2'b10, 4'h0, 4'h2, 12'h000, 12'h222);
    repeat (6) drive(2'b11, 2'b00, 4'h1, 4'h2, '0, '0);
    repeat (4) drive(2'b10, 2'b00, 4'h0, 4'h2, '0, '0);
    drive(2'b11, 2'b00, 4'h1, 4'h2, '0, '0);
    drive(2'b01, 2'b00, 4'hF, 4'h0, '0, '0);
    idle(3);

    repeat (300)
      drive(NREQ'($urandom_range(0, 3)), NREQ'($urandom_range(0, 3)),
            AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
            DW'($urandom_range(0, 4095)), DW'($urandom_range(0, 4095)));
    idle(4);

    // Reset in the cycle after a read grant: the read must vanish.
    drive(2'b01, 2'b00, 4'h5, 4'h0, '0, '0);
    req = '0;
    #1 sys_rst_n = 1'b0;
    #1;
    check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("mid_rst_raddr", 32'(mem_raddr), 32'd0);
    check("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("mid_rst_waddr", 32'(mem_waddr), 32'd0);
    check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    check("mid_rst_init_done", 32'(init_done), 32'd0);
    check("mid_rst_gnt", 32'(req_gnt), 32'd0);
    check("mid_rst_rsp", 32'({rsp_valid, rsp_data}), 32'd0);
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    idle(DEPTH + 2);
    drive(2'b11, 2'b00, 4'h5, 4'h2, '0, '0);
    drive(2'b10, 2'b00, 4'h0, 4'hA, '0, '0);
    idle(4);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("wmask_zero", 32'(wmask_bad), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
